// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     Instrucao;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] saida_Imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid, Instrucao, out_ready,
        input  in_ready, out_valid, saida_Imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, Instrucao, out_ready,
        output in_ready, out_valid, saida_Imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RISC-V immediate decoder feeding a 2-entry skid FIFO
// Also keeps a saturating count of accepted words with unrecognised opcodes.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_gen_pipe_if.slave    bus,
    input  logic             flush,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] illegal_count
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    entry_t      dec;
    logic [31:0] imm32;
    logic [31:0] ins;

    entry_t      mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        accept;
    logic        pop;
    entry_t      head;

    assign ins = bus.Instrucao;

    always_comb begin
        imm32       = '0;
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b1;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                imm32       = {{20{ins[31]}}, ins[31:20]};
                dec.fmt     = FMT_I;
                dec.illegal = 1'b0;
            end
            7'b0100011: begin
                imm32       = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                dec.fmt     = FMT_S;
                dec.illegal = 1'b0;
            end
            7'b1100011: begin
                imm32       = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                dec.fmt     = FMT_B;
                dec.illegal = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                imm32       = {ins[31:12], 12'b0};
                dec.fmt     = FMT_U;
                dec.illegal = 1'b0;
            end
            7'b1101111: begin
                imm32       = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                dec.fmt     = FMT_J;
                dec.illegal = 1'b0;
            end
            default: begin
                imm32       = '0;
                dec.fmt     = FMT_NONE;
                dec.illegal = 1'b1;
            end
        endcase
        // Illegal words carry imm32 = 0, so filling with bit 31 would be wrong for them.
        for (int i = 0; i < XLEN; i++) begin
            dec.imm[i] = ins[31] & ~dec.illegal;
        end
        dec.imm[31:0] = imm32;
    end

    // Ready depends only on registered occupancy, never on out_ready.
    assign bus.in_ready  = ~count[1];
    assign bus.out_valid = (count != 2'd0);
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign head          = mem[rd_ptr];

    assign bus.saida_Imm   = bus.out_valid ? head.imm     : '0;
    assign bus.out_fmt     = bus.out_valid ? head.fmt     : FMT_NONE;
    assign bus.out_illegal = bus.out_valid ? head.illegal : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, accept} - {1'b0, pop};
        end
    end

    // Counts accepts even when flush drops them; flush never touches the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count <= '0;
        end else if (cnt_clear) begin
            illegal_count <= '0;
        end else if (accept && dec.illegal && (illegal_count != '1)) begin
            illegal_count <= illegal_count + 1'b1;
        end
    end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter CNT_W, 16, width of the illegal-opcode counter.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port in_valid  input  1  Instrucao carries a valid word.
REQ-006 Port in_ready  output  1  block can accept a word this cycle; driven only from registered state.
REQ-007 Port Instrucao  input  32  RISC-V instruction word.
REQ-008 Port flush  input  1  discards all buffered entries.
REQ-009 Port cnt_clear  input  1  zeroes illegal_count.
REQ-010 Port out_valid  output  1  head entry is valid.
REQ-011 Port out_ready  input  1  consumer accepts the head entry.
REQ-012 Port saida_Imm  output  XLEN  sign-extended immediate of the head entry.
REQ-013 Port out_fmt  output  3  format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-014 Port out_illegal  output  1  head opcode is unrecognised.
REQ-015 Port illegal_count  output  CNT_W  saturating count of accepted illegal words.

Function
REQ-016 Decode is on Instrucao[6:0]: I for 0000011, 0010011, 1100111, 1110011; S for 0100011; B for 1100011; U for 0110111, 0010111; J for 1101111.
REQ-017 I imm = sext(Instrucao[31:20]); S imm = sext({[31:25],[11:7]}); B imm = sext({[31],[7],[30:25],[11:8],0}).
REQ-018 U imm = sext({Instrucao[31:12],12'b0}); J imm = sext({[31],[19:12],[20],[30:21],0}); sign extension uses Instrucao[31] up to XLEN.
REQ-019 Any other opcode: imm = 0, fmt = 0, illegal = 1; recognised opcodes set illegal = 0.
REQ-020 Decode happens before storage; each buffer entry holds {imm, fmt, illegal}.
REQ-021 Buffer is a 2-entry FIFO (skid buffer); an accept occurs when in_valid and in_ready; a pop occurs when out_valid and out_ready.
REQ-022 in_ready = 1 when fewer than 2 entries are held, evaluated from registered occupancy only.
REQ-023 Latency: a word accepted in cycle N is visible on the outputs in cycle N+1 when the buffer was empty; order is strictly FIFO.
REQ-024 Simultaneous accept and pop with 1 entry: occupancy stays 1, new entry becomes head next cycle; with 2 entries no accept is possible.
REQ-025 Full throughput: with out_ready held at 1, one word per cycle passes with in_ready continuously 1.
REQ-026 Head outputs hold stable while out_valid = 1 and out_ready = 0.
REQ-027 When out_valid = 0, saida_Imm, out_fmt and out_illegal are driven to 0.
REQ-028 flush = 1: occupancy goes to 0 next cycle; an accept in the same cycle is dropped; a pop in the same cycle is still a completed pop.
REQ-029 illegal_count increments by 1 on each accept with illegal = 1, including an accept dropped by flush; it saturates at all-ones.
REQ-030 cnt_clear = 1 sets illegal_count to 0 next cycle, overriding a simultaneous increment.
REQ-031 flush does not affect illegal_count.

Reset
REQ-032 While rst_n = 0 the buffer is empty, out_valid = 0, saida_Imm = 0, out_fmt = 0, out_illegal = 0, and illegal_count = 0.
REQ-033 After reset release, in_ready = 1 from the first clock edge.
REQ-034 Reset asserted mid-transfer discards all entries immediately without waiting for a clock edge.

Verification
REQ-035 XLEN=32, accept 0xFFC00513 (addi, imm -4) -> next cycle out_valid=1, saida_Imm=0xFFFFFFFC, fmt=1, illegal=0.
REQ-036 XLEN=64, accept 0x800000EF (jal, imm min) -> saida_Imm=0xFFFFFFFFFFF00000, fmt=5; accept 0x12345037 (lui) -> saida_Imm=0x0000000012345000, fmt=4.
REQ-037 Hold out_ready=0 and offer 3 words -> first two accepted, in_ready=0 after the second accept, and the third is held at input; release out_ready -> outputs appear in order, none lost.
REQ-038 Buffer full, assert flush and in_valid together -> next cycle out_valid=0, in_ready=1, offered word absent.
REQ-039 Stream 0x0000007F (illegal) with CNT_W=4 for 20 accepts -> illegal_count stops at 15, out_illegal=1, imm=0, fmt=0; cnt_clear together with an illegal accept -> count 0.
REQ-040 Drop rst_n asynchronously with 2 entries held -> out_valid=0 and illegal_count=0 before the next clock edge.
